// File: rtl/ram_loader.sv
// ram_loader: serial-to-parallel RAM program loader.
// A host raises load_en, then clocks NUM_BYTES bytes in MSB first on sclk/sdata.
// Each assembled byte is written to the RAM program port with a one-cycle
// prog_mode strobe at consecutive addresses starting at 0.
// Optional feature: define RAM_LOADER_CKSUM_EN to expect one extra checksum
// byte after the data, compared against the modulo-256 sum of the data bytes.
module ram_loader #(
    parameter int NUM_BYTES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic       sclk,
    input  logic       sdata,
    output logic       prog_mode,
    output logic [3:0] prog_addr,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       done,
    output logic       cksum_err
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WRITE = 3'd2,
`ifdef RAM_LOADER_CKSUM_EN
        CKSUM = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t     state;

    // Synchronizer chains for the asynchronous host pins
    logic       load_s1, load_s2, load_d;
    logic       sclk_s1, sclk_s2, sclk_d;
    logic       sdata_s1, sdata_s2;

    logic       load_rise;
    logic       sclk_rise;

    // Seven stored bits; the eighth (newest) bit is combined in directly when
    // the byte completes, so the full 8-bit value never needs its own register.
    logic [6:0] shreg;
    logic [7:0] next_byte;
    logic [2:0] bit_cnt;
    logic [3:0] byte_idx;

`ifdef RAM_LOADER_CKSUM_EN
    logic [7:0] sum;
`endif

    assign load_rise = load_s2 & ~load_d;
    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign next_byte = {shreg, sdata_s2};

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_s1  <= 1'b0;
            load_s2  <= 1'b0;
            load_d   <= 1'b0;
            sclk_s1  <= 1'b0;
            sclk_s2  <= 1'b0;
            sclk_d   <= 1'b0;
            sdata_s1 <= 1'b0;
            sdata_s2 <= 1'b0;
        end else begin
            load_s1  <= load_en;
            load_s2  <= load_s1;
            load_d   <= load_s2;
            sclk_s1  <= sclk;
            sclk_s2  <= sclk_s1;
            sclk_d   <= sclk_s2;
            sdata_s1 <= sdata;
            sdata_s2 <= sdata_s1;
        end
    end

    // Session FSM with registered outputs; busy/done are updated together with
    // the state so they always reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_mode <= 1'b0;
            prog_addr <= '0;
            w_data    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
`ifdef RAM_LOADER_CKSUM_EN
            sum       <= '0;
            cksum_err <= 1'b0;
`endif
        end else begin
            prog_mode <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (load_rise) begin
                        state    <= SHIFT;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
`ifdef RAM_LOADER_CKSUM_EN
                        sum       <= '0;
                        cksum_err <= 1'b0;
`endif
                    end
                end

                SHIFT: begin
                    if (!load_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sclk_rise) begin
                        shreg   <= next_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state     <= WRITE;
                            prog_mode <= 1'b1;
                            prog_addr <= byte_idx;
                            w_data    <= next_byte;
                        end
                    end
                end

                WRITE: begin
`ifdef RAM_LOADER_CKSUM_EN
                    sum <= sum + w_data;
`endif
                    if (!load_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (byte_idx < LAST_IDX) begin
                        byte_idx <= byte_idx + 4'd1;
                        state    <= SHIFT;
                    end else begin
`ifdef RAM_LOADER_CKSUM_EN
                        state <= CKSUM;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end

`ifdef RAM_LOADER_CKSUM_EN
                CKSUM: begin
                    if (!load_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sclk_rise) begin
                        shreg   <= next_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            cksum_err <= (next_byte != sum);
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef RAM_LOADER_CKSUM_EN
    assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader.
// Expected writes are queued as each byte is clocked out by the host model and
// checked against the RAM program port when prog_mode pulses. A second
// instance with NUM_BYTES=1 shares the serial pins but has its own load_en.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic       load_en1 = 1'b0;
    logic       sclk = 1'b0;
    logic       sdata = 1'b0;

    logic       prog_mode, busy, done, cksum_err;
    logic [3:0] prog_addr;
    logic [7:0] w_data;
    logic       prog_mode1, busy1, done1, cksum_err1;
    logic [3:0] prog_addr1;
    logic [7:0] w_data1;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned extra = 0;
    int unsigned extra1 = 0;
    int unsigned pulse_err = 0;
    logic        pm_prev = 1'b0;

    logic [11:0] sb_q[$];
    logic [11:0] sb1_q[$];

    ram_loader dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .sclk(sclk), .sdata(sdata),
        .prog_mode(prog_mode), .prog_addr(prog_addr), .w_data(w_data),
        .busy(busy), .done(done), .cksum_err(cksum_err)
    );

    ram_loader #(.NUM_BYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_en(load_en1), .sclk(sclk), .sdata(sdata),
        .prog_mode(prog_mode1), .prog_addr(prog_addr1), .w_data(w_data1),
        .busy(busy1), .done(done1), .cksum_err(cksum_err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitors: pop an expected {addr,data} on every write strobe
    always @(negedge clk) begin
        logic [11:0] e;
        if (prog_mode) begin
            if (sb_q.size() == 0) extra++;
            else begin
                e = sb_q.pop_front();
                check("addr", 32'(prog_addr), 32'(e[11:8]));
                check("data", 32'(w_data), 32'(e[7:0]));
            end
        end
        if (prog_mode && pm_prev) pulse_err++;
        pm_prev = prog_mode;
        if (prog_mode1) begin
            if (sb1_q.size() == 0) extra1++;
            else begin
                e = sb1_q.pop_front();
                check("addr1", 32'(prog_addr1), 32'(e[11:8]));
                check("data1", 32'(w_data1), 32'(e[7:0]));
            end
        end
    end

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // One serial bit: 5 clk low, rise, 5 clk high (sclk period 10 clk)
    task automatic send_bit(input logic b);
        sdata = b;
        sclk  = 1'b0;
        wait_clk(5);
        sclk = 1'b1;
        wait_clk(5);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic push_send(input logic [3:0] a, input logic [7:0] v);
        sb_q.push_back({a, v});
        send_byte(v);
    endtask

    task automatic start_session();
        sclk = 1'b0;
        load_en = 1'b0;
        wait_clk(4);
        load_en = 1'b1;
        wait_clk(4);
    endtask

    task automatic wait_done(input int unsigned limit);
        int unsigned n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_sb_left"}, sb_q.size(), 0);
        check({tag, "_extra"}, extra, 0);
    endtask

    // Full session of 16 bytes base+i, with optional checksum byte
    task automatic full_load(input logic [7:0] base, input logic inc, input logic [7:0] ck);
        start_session();
        for (int i = 0; i < 16; i++)
            push_send(4'(i), inc ? 8'(base + 8'(i)) : base);
`ifdef RAM_LOADER_CKSUM_EN
        send_byte(ck);
`else
        if (ck != 8'h00) sdata = 1'b0;
`endif
        wait_done(40);
    endtask

    initial begin
        int unsigned n;

        // Reset state
        wait_clk(3);
        check("rst_prog_mode", 32'(prog_mode), 0);
        check("rst_prog_addr", 32'(prog_addr), 0);
        check("rst_w_data", 32'(w_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cksum_err", 32'(cksum_err), 0);
        rst_n = 1'b1;
        wait_clk(3);

        // Full load 0x00..0x0F
        full_load(8'h00, 1'b1, 8'h78);
        check("full_done", 32'(done), 1);
        check("full_busy", 32'(busy), 0);
        check("full_cksum_err", 32'(cksum_err), 0);
        end_checks("full");
        check("full_pulse_width", pulse_err, 0);

        // Restart from DONE: done clears, 0xA5 goes to addr 0
        start_session();
        n = 0;
        while (done && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("restart_done_clr", 32'(done), 0);
        check("restart_busy", 32'(busy), 1);
        push_send(4'd0, 8'hA5);
        load_en = 1'b0;
        wait_clk(8);
        end_checks("restart");
        check("restart_busy_off", 32'(busy), 0);

        // Abort after 3 bytes and 4 bits
        start_session();
        for (int i = 0; i < 3; i++) push_send(4'(i), 8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        load_en = 1'b0;
        wait_clk(8);
        end_checks("abort");
        check("abort_done", 32'(done), 0);
        check("abort_busy", 32'(busy), 0);

        // Reset mid-bit of byte 5
        start_session();
        for (int i = 0; i < 4; i++) push_send(4'(i), 8'h50 + 8'(i));
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        sclk = 1'b0;
        wait_clk(2);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_prog_mode", 32'(prog_mode), 0);
        check("mrst_prog_addr", 32'(prog_addr), 0);
        check("mrst_w_data", 32'(w_data), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_cksum_err", 32'(cksum_err), 0);
        load_en = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        end_checks("mrst");
        start_session();
        push_send(4'd0, 8'h77);
        push_send(4'd1, 8'h88);
        load_en = 1'b0;
        wait_clk(8);
        end_checks("mrst_new");

`ifdef RAM_LOADER_CKSUM_EN
        // Checksum: sixteen 0x10 sum to 0x00
        full_load(8'h10, 1'b0, 8'h00);
        check("ck_ok_done", 32'(done), 1);
        check("ck_ok_err", 32'(cksum_err), 0);
        end_checks("ck_ok");
        full_load(8'h10, 1'b0, 8'h01);
        check("ck_bad_done", 32'(done), 1);
        check("ck_bad_err", 32'(cksum_err), 1);
        end_checks("ck_bad");
`endif

        // NUM_BYTES=1 instance: single write of 0x3C
        load_en = 1'b0;
        sclk = 1'b0;
        load_en1 = 1'b1;
        wait_clk(4);
        sb1_q.push_back({4'd0, 8'h3C});
        send_byte(8'h3C);
        n = 0;
        while (!done1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("nb1_done", 32'(done1), 1);
        check("nb1_busy", 32'(busy1), 0);
        check("nb1_cksum_err", 32'(cksum_err1), 0);
        check("nb1_sb_left", sb1_q.size(), 0);
        check("nb1_extra", extra1, 0);
        check("nb1_main_idle", 32'(busy), 0);
        check("pulse_width", pulse_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
